// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared constants and FSM state type for the SRAM array controller
// Purpose: array geometry defaults and the controller state encoding, imported by
//          the interface, the init walker and the top.
// Ports: none (package).
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 64;

  // INIT is the address-setup cycle of a clear-walk word; it is followed by the
  // same WRITE/HOLD pair that a normal write uses.
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETUP,
    WRITE,
    HOLD,
    SENSE,
    CAPTURE,
    RESP
  } sram_state_e;

endpackage

// File: rtl/sram_array_ctrl_if.sv
// rtl/sram_array_ctrl_if.sv - request/response/status bundle of sram_array_ctrl
// Purpose: groups the requester-facing signals of the SRAM array controller.
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata  single-word request channel
//   rsp_valid/rsp_ready/rsp_rdata                  read response channel
//   busy, init_done                                controller status
// Modports: master = requester side, slave = controller side.
interface sram_array_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, busy, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, busy, init_done
  );

endinterface

// File: rtl/sram_init_walker.sv
// rtl/sram_init_walker.sv - address counter and done flag for the post-reset clear walk
// Purpose: tracks which word the clear walk is on and when the last word has been written.
// Ports:
//   clk, rst       clock, synchronous active-high reset (restarts the walk at 0)
//   step_i         pulse in the HOLD cycle of each walked word
//   next_addr_o    address of the following word
//   last_o         current word is the top address
//   done_o         walk finished; stays high until reset
module sram_init_walker
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              last_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else if (step_i && !done_q) begin
      if (last_o) begin
        done_q <= 1'b1;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign next_addr_o = addr_q + 1'b1;
  assign last_o      = &addr_q;
  assign done_o      = done_q;

endmodule

// File: rtl/sram_array_ctrl.sv
// rtl/sram_array_ctrl.sv - single-word request sequencer for the compiled SRAM array
// Purpose: accepts one read/write at a time, drives the array address/data/strobe
//          pins with setup and hold cycles, captures dout and returns read data.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       request channel, read response channel, busy/init_done status
//   sram_addr/din     array address and write data buses
//   sram_dout         array read data bus
//   sram_write_en     array write strobe
//   sram_sense_en     array sense-amp enable
// Build option: SRAM_ARRAY_CTRL_INIT_CLEAR_EN adds a post-reset walk writing 0 to
//               every word before requests are accepted.
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int SENSE_CYCLES = 1  // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst,
  sram_array_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              sram_write_en,
  output logic              sram_sense_en
);

`ifdef SRAM_ARRAY_CTRL_INIT_CLEAR_EN
  localparam sram_state_e RESET_STATE = INIT;
`else
  localparam sram_state_e RESET_STATE = IDLE;
`endif

  sram_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        sense_cnt_q, sense_cnt_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_din_q, sram_din_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              write_en_q, sense_en_q, rsp_valid_q, busy_q, req_ready_q;
  logic              init_done, init_done_d;

`ifdef SRAM_ARRAY_CTRL_INIT_CLEAR_EN
  logic              walk_step, walk_last, walk_done;
  logic [ADDR_W-1:0] walk_next_addr;

  sram_init_walker #(.ADDR_W(ADDR_W)) u_walker (
    .clk        (clk),
    .rst        (rst),
    .step_i     (walk_step),
    .next_addr_o(walk_next_addr),
    .last_o     (walk_last),
    .done_o     (walk_done)
  );

  assign init_done = walk_done;
`else
  assign init_done = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sense_cnt_d = sense_cnt_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done;
`ifdef SRAM_ARRAY_CTRL_INIT_CLEAR_EN
    walk_step   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // req_ready_q already folds in init_done, so it alone qualifies the handshake.
        if (bus.req_valid && req_ready_q) begin
          sram_addr_d = bus.req_addr;
          if (bus.req_we) begin
            sram_din_d = bus.req_wdata;
          end
          we_d    = bus.req_we;
          state_d = SETUP;
        end
      end
      INIT: state_d = WRITE;
      SETUP: begin
        if (we_q) begin
          state_d = WRITE;
        end else begin
          sense_cnt_d = 3'(SENSE_CYCLES - 1);
          state_d     = SENSE;
        end
      end
      WRITE: state_d = HOLD;
      HOLD: begin
`ifdef SRAM_ARRAY_CTRL_INIT_CLEAR_EN
        if (!init_done) begin
          walk_step = 1'b1;
          if (walk_last) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            // din stays at its reset value of 0 for the whole walk.
            sram_addr_d = walk_next_addr;
            state_d     = INIT;
          end
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      SENSE: begin
        if (sense_cnt_q == 3'd0) begin
          state_d = CAPTURE;
        end else begin
          sense_cnt_d = sense_cnt_q - 3'd1;
        end
      end
      CAPTURE: begin
        rsp_rdata_d = sram_dout;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a register loaded from the next state, so strobes and
  // status line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      we_q        <= 1'b0;
      sense_cnt_q <= 3'd0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      rsp_rdata_q <= '0;
      write_en_q  <= 1'b0;
      sense_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= (RESET_STATE != IDLE);
      req_ready_q <= (RESET_STATE == IDLE);
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sense_cnt_q <= sense_cnt_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      rsp_rdata_q <= rsp_rdata_d;
      write_en_q  <= (state_d == WRITE);
      sense_en_q  <= (state_d == SENSE);
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
      req_ready_q <= (state_d == IDLE) && init_done_d;
    end
  end

  assign sram_addr     = sram_addr_q;
  assign sram_din      = sram_din_q;
  assign sram_write_en = write_en_q;
  assign sram_sense_en = sense_en_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done;

endmodule

// File: doc/sram_array_ctrl.md
Name: sram_array_ctrl

Overview:
- Initiator-side controller for the 1024x64 compiled SRAM array.
- Accepts single-word read/write requests on a valid/ready interface and sequences the array's address, data, write_en and sense_en pins with the required setup and hold cycles.
- Captures dout after sensing and returns read data on a valid/ready response port.
- Sits between the DVS event buffering logic and the SRAM macro; it is the only driver of the array pins.

Parameters:
- ADDR_W, 10, address width; array depth is 2**ADDR_W words.
- DATA_W, 64, word width.
- SENSE_CYCLES, 1, cycles sram_sense_en is held high per read; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_W  read data.
- busy  out  1  high in any state other than IDLE.
- init_done  out  1  array ready for requests.
- sram_addr  out  ADDR_W  to array addr bus.
- sram_din  out  DATA_W  to array din bus.
- sram_dout  in  DATA_W  from array dout bus.
- sram_write_en  out  1  array write strobe.
- sram_sense_en  out  1  array sense-amp enable.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - sram_addr=0, sram_din=0, sram_write_en=0, sram_sense_en=0.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - State is IDLE.
  - init_done=1 from the first cycle after rst deasserts; see Optional Feature for the exception.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: req_ready = init_done. A transfer occurs when req_valid && req_ready.
    - Latch req_addr into sram_addr and req_wdata into sram_din (write only; sram_din is unchanged on reads).
    - Latch req_we. Go to SETUP.
  - SETUP (1 cycle): address and data stable, both strobes low. Go to WRITE if latched we, else SENSE.
  - WRITE (1 cycle): sram_write_en=1. Go to HOLD.
  - HOLD (1 cycle): strobes low; sram_addr and sram_din held. Go to IDLE.
  - SENSE: sram_sense_en=1 for exactly SENSE_CYCLES cycles, timed by a down-counter. Go to CAPTURE.
  - CAPTURE (1 cycle): sense_en low. Register sram_dout into rsp_rdata at the end of the cycle. Go to RESP.
  - RESP: rsp_valid=1 and rsp_rdata stable until rsp_valid && rsp_ready. On that handshake, clear rsp_valid the next cycle and go to IDLE.
- req_ready=0 in every state except IDLE. At most one transaction is outstanding.
- Latency:
  - Write: accept edge to next possible accept is 4 cycles.
  - Read, SENSE_CYCLES=1: rsp_valid rises 4 cycles after the accept edge.
  - In general, read latency is 3+SENSE_CYCLES.
- Writes produce no response.
- Invariants:
  - sram_write_en and sram_sense_en are never high in the same cycle.
  - sram_addr and sram_din change only on the IDLE->SETUP edge, or in the init walker.
- rsp_ready held high early has no effect outside RESP.
- Reset mid-operation: on the cycle after rst is sampled high, all strobes are low and rsp_valid=0. The state is IDLE and the in-flight request is discarded, with no partial write completion guaranteed.
- Address wrap: none. Each request addresses exactly one word; the full range 0..2**ADDR_W-1 is legal.

Optional Feature:
- Macro: SRAM_ARRAY_CTRL_INIT_CLEAR_EN.
- When defined:
  - After reset the FSM enters INIT and writes 0 to every address 0..2**ADDR_W-1 in ascending order.
  - Each word uses the same SETUP/WRITE/HOLD timing: 3 cycles per word, 3072 cycles total at default parameters.
  - init_done=0 and req_ready=0 throughout INIT. init_done rises the cycle after the final HOLD, and stays high until the next reset.
  - Reset during INIT restarts the walk at address 0.
- When undefined: no INIT state; init_done=1 from the first cycle after reset.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - SRAM_ADDR_W=10 and SRAM_DATA_W=64 constants.
  - The state enum typedef (IDLE, INIT, SETUP, WRITE, HOLD, SENSE, CAPTURE, RESP).
- One natural sub-module, sram_init_walker: address counter plus done flag. It is instantiated only under the macro.
- All other logic stays in the top module.

Test Plan:
- Write then read: write addr 0x3A5 data 0xDEADBEEF_01234567, then read 0x3A5 -> write_en high exactly 1 cycle, 2 cycles after accept; rsp_valid 4 cycles after read accept; rsp_rdata=0xDEADBEEF_01234567.
- Boundaries: write 0x000=all-ones and 0x3FF=0x5555..55, read both -> correct data, no aliasing between the two addresses.
- Response backpressure: read with rsp_ready=0 for 10 cycles -> rsp_valid held and rsp_rdata stable for all 10 cycles; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Reset during SENSE: assert rst for 1 cycle while sense_en=1 -> next cycle sense_en=0, rsp_valid=0, busy=0, req_ready=1.
- Strobe exclusivity: 200 random back-to-back requests -> write_en && sense_en never both high; sram_addr never changes while either strobe is high.
- Init clear (macro defined): preload array with nonzero data, reset -> init_done after 3072 cycles; a read of 0x155 returns 0; req_valid during INIT is not accepted.
